// File: rtl/xunit_msched.sv
// SHA-256 message-schedule expander: loads M_0..M_15 on in0, emits W_0..W_63 on out0.
// Optional K-constant ROM on out1 when XUNIT_MSCHED_KROM_EN is defined.
module xunit_msched #(
    parameter int unsigned DELAY_W = 32,
    parameter int unsigned DATA_W  = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               running,
    input  logic               run,
    output logic               done,
    input  logic [DATA_W-1:0]  in0,
    output logic [DATA_W-1:0]  out0,
    output logic [DATA_W-1:0]  out1,
    input  logic [DELAY_W-1:0] delay0
);

    localparam logic [6:0] T_END  = 7'd64;
    localparam logic [6:0] T_LOAD = 7'd16;

    logic [DELAY_W-1:0] delay_q, delay_d;
    logic [6:0]         t_q, t_d;
    logic [DATA_W-1:0]  win_q [16];
    logic [DATA_W-1:0]  win_d [16];
    logic [DATA_W-1:0]  out0_q, out0_d;
    logic [DATA_W-1:0]  w_new;
    logic               active;

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] sig0(input logic [DATA_W-1:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [DATA_W-1:0] sig1(input logic [DATA_W-1:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // A word is produced only once the start delay has fully elapsed.
    assign active = !run && running && (t_q < T_END) && (delay_q == '0);

    always_comb begin
        if (t_q < T_LOAD) begin
            w_new = in0;
        end else begin
            w_new = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
        end
    end

    always_comb begin
        delay_d = delay_q;
        t_d     = t_q;
        out0_d  = out0_q;
        for (int i = 0; i < 16; i++) begin
            win_d[i] = win_q[i];
        end
        if (run) begin
            delay_d = delay0;
            t_d     = '0;
        end else if (running && (t_q < T_END)) begin
            if (delay_q != '0) begin
                delay_d = delay_q - DELAY_W'(1);
            end else begin
                out0_d = w_new;
                for (int i = 0; i < 15; i++) begin
                    win_d[i] = win_q[i+1];
                end
                win_d[15] = w_new;
                t_d       = t_q + 7'd1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            delay_q <= '0;
            t_q     <= T_END;
            out0_q  <= '0;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            delay_q <= delay_d;
            t_q     <= t_d;
            out0_q  <= out0_d;
            for (int i = 0; i < 16; i++) begin
                win_q[i] <= win_d[i];
            end
        end
    end

    assign done = (t_q == T_END);
    assign out0 = out0_q;

`ifdef XUNIT_MSCHED_KROM_EN
    localparam logic [31:0] K_ROM [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
        32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
        32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
        32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
        32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
        32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
        32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
        32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
        32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic [DATA_W-1:0] out1_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out1_q <= '0;
        end else if (active) begin
            out1_q <= DATA_W'(K_ROM[t_q[5:0]]);
        end
    end

    assign out1 = out1_q;
`else
    assign out1 = '0;
`endif

endmodule

// File: tb/tb_xunit_msched.sv
// Scoreboard bench for xunit_msched: reference schedule words are queued at run and
// popped as the DUT produces them; covers delay, running gaps, abort and reset.
module tb_xunit_msched;

    typedef logic [31:0] blk_t [16];
    typedef logic [31:0] sched_t [64];

    logic        clk = 1'b0;
    logic        rst;
    logic        running;
    logic        run;
    logic        done;
    logic [31:0] in0;
    logic [31:0] out0;
    logic [31:0] out1;
    logic [31:0] delay0;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q [$];
    logic [31:0] last_w = '0;
    bit          busy = 1'b0;
    logic [31:0] got_w [64];

    xunit_msched #(.DELAY_W(32), .DATA_W(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .running (running),
        .run     (run),
        .done    (done),
        .in0     (in0),
        .out0    (out0),
        .out1    (out1),
        .delay0  (delay0)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic build_sched(input blk_t b, output sched_t w);
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin
                w[i] = b[i];
            end else begin
                w[i] = (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
                     + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
            end
        end
    endtask

    task automatic cyc(input logic r, input logic rn, input logic [31:0] d, input bit prod,
                       input int tidx);
        logic [31:0] w;
        @(negedge clk);
        run     = r;
        running = rn;
        in0     = d;
        @(posedge clk);
        #1;
        if (r) busy = 1'b1;
        if (prod) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_underflow: got %08h expected none queued", out0);
            end else begin
                w = exp_q.pop_front();
                check("w_t", out0, w);
                last_w = w;
            end
            got_w[tidx] = out0;
            if (tidx == 63) busy = 1'b0;
`ifdef XUNIT_MSCHED_KROM_EN
            if (tidx == 0)  check("k_0", out1, 32'h428a2f98);
            if (tidx == 1)  check("k_1", out1, 32'h71374491);
            if (tidx == 63) check("k_63", out1, 32'hc67178f2);
`endif
        end else begin
            check("out0_hold", out0, last_w);
        end
        check("done", {31'b0, done}, {31'b0, ~busy});
`ifndef XUNIT_MSCHED_KROM_EN
        check("out1_zero", out1, 32'h0);
`endif
    endtask

    // Run one block: run pulse, dly wait cycles, then produce words up to stop_at.
    task automatic run_seq(input blk_t b, input int dly, input int gap_at, input int stop_at);
        sched_t w;
        build_sched(b, w);
        exp_q.delete();
        for (int i = 0; i < 64; i++) exp_q.push_back(w[i]);
        delay0 = dly;
        cyc(1'b1, 1'b1, $urandom, 1'b0, 0);
        for (int i = 0; i < dly; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, 0);
        for (int t = 0; t < stop_at; t++) begin
            if (t == gap_at) begin
                for (int g = 0; g < 3; g++) cyc(1'b0, 1'b0, $urandom, 1'b0, 0);
            end
            cyc(1'b0, 1'b1, (t < 16) ? b[t] : $urandom, 1'b1, t);
        end
    endtask

    blk_t abc_blk, rnd_a, rnd_b, rnd_c;

    initial begin
        rst     = 1'b1;
        run     = 1'b0;
        running = 1'b0;
        in0     = '0;
        delay0  = '0;
        for (int i = 0; i < 16; i++) begin
            abc_blk[i] = '0;
            rnd_a[i]   = $urandom;
            rnd_b[i]   = $urandom;
            rnd_c[i]   = $urandom;
        end
        abc_blk[0]  = 32'h61626380;
        abc_blk[15] = 32'h00000018;

        repeat (2) @(negedge clk);
        check("rst_out0", out0, 32'h0);
        check("rst_out1", out1, 32'h0);
        check("rst_done", {31'b0, done}, 32'h1);
        rst = 1'b0;

        // Idle after reset: running high and in0 toggling must change nothing.
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, 0);

        run_seq(abc_blk, 0, -1, 64);
        check("abc_w16", got_w[16], 32'h61626380);
        check("abc_w17", got_w[17], 32'h000f0000);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, 0);

        run_seq(abc_blk, 5, -1, 64);
        run_seq(rnd_a, 2, 20, 64);

        // Abort at t = 30 and restart with a fresh block.
        run_seq(rnd_a, 0, -1, 30);
        run_seq(rnd_b, 0, -1, 64);

        // Asynchronous reset mid-sequence at t = 40.
        run_seq(rnd_c, 1, -1, 40);
        @(negedge clk);
        rst = 1'b1;
        #1;
        busy   = 1'b0;
        last_w = '0;
        check("arst_out0", out0, 32'h0);
        check("arst_out1", out1, 32'h0);
        check("arst_done", {31'b0, done}, 32'h1);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, $urandom, 1'b0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
